// File: rtl/gray_display_driver.sv
// -----------------------------------------------------------------------------
// gray_display_driver
//
// Consumes the Gray-coded output of an N-bit counter. It:
//   * re-registers the Gray word twice (current and previous samples),
//   * converts the current sample to binary and registers it onto bin_out,
//   * pulses step for one cycle whenever the registered Gray value changes,
//   * (optionally) flags any transition that flips more than one Gray bit,
//   * scans bin_out as hexadecimal onto a multiplexed common-anode
//     seven-segment display, one nibble per digit.
//
// Parameters
//   N         Gray/binary width. Multiple of 4, 4..16. DIGITS = N/4.
//   SCAN_MAX  Prescaler terminal count. Each digit is lit for SCAN_MAX+1
//             clk cycles (1 ms at 100 MHz with the default).
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous, active-low reset
//   gray_in  in   N  Gray code from the counter
//   bin_out  out  N  registered binary equivalent of gray_in
//   step     out  1  one-cycle pulse when the registered Gray value changes
//   err      out  1  sticky multi-bit-transition flag (cleared only by rst)
//   an       out  4  active-low digit enables, an[0] = least-significant nibble
//   seg      out  7  active-low segments {g,f,e,d,c,b,a}
//   dp       out  1  active-low decimal point, lit on digit 0 while err=1
//
// Build option
//   GRAY_CHECK_EN  When defined, the transition checker, err and dp are
//                  active. When undefined, the checker is removed, err is
//                  tied to 0 and dp to 1; everything else is identical.
//
// Latency
//   gray_in -> bin_out / step / err : 2 cycles
//   bin_out -> seg of the lit digit : 1 cycle
//   an and seg switch digits on the same clock edge (no ghosting).
// -----------------------------------------------------------------------------
module gray_display_driver #(
    parameter int N        = 8,
    parameter int SCAN_MAX = 100000 - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] bin_out,
    output logic         step,
    output logic         err,
    output logic [3:0]   an,
    output logic [6:0]   seg,
    output logic         dp
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int DIGITS = N / 4;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW     = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;

    localparam logic [PW-1:0] SCAN_TC    = PW'(SCAN_MAX);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Active-low one-hot anode pattern for digit d. Positions at DIGITS and
    // above never match, so unused anodes stay dark.
    function automatic logic [3:0] anode_decode(input logic [IW-1:0] d);
        logic [3:0] a;
        a = 4'b1111;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == d) begin
                a[k] = 1'b0;
            end
        end
        return a;
    endfunction

    // Nibble of v shown on digit d (digit 0 = bits [3:0]).
    function automatic logic [3:0] nibble_at(input logic [N-1:0] v,
                                             input logic [IW-1:0] d);
        logic [3:0] nib;
        nib = v[3:0];
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == d) begin
                nib = v[k*4 +: 4];
            end
        end
        return nib;
    endfunction

    // Hex digit to active-low {g,f,e,d,c,b,a}; lower-case b and d keep them
    // distinguishable from 8 and 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Gray capture, conversion and change detect
    // -------------------------------------------------------------------------
    logic [N-1:0] g_q;      // current Gray sample
    logic [N-1:0] g_prev;   // sample from the previous cycle
    logic [N-1:0] bin_n;    // binary equivalent of g_q

    // Each binary bit is the XOR of all Gray bits at or above it; walking
    // from the MSB down reuses the running result.
    // NOTE: every variable written in an always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        bin_n      = '0;
        bin_n[N-1] = g_q[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            bin_n[i] = bin_n[i+1] ^ g_q[i];
        end
    end

    // step compares the same pair the checker sees, so it lands in the same
    // cycle bin_out shows the new value.
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge value of the others; g_prev gets the old g_q, not the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_q     <= '0;
            g_prev  <= '0;
            bin_out <= '0;
            step    <= 1'b0;
        end else begin
            g_q     <= gray_in;
            g_prev  <= g_q;
            bin_out <= bin_n;
            step    <= (g_q != g_prev);
        end
    end

    // -------------------------------------------------------------------------
    // Scan prescaler and digit index
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic          scan_tc;

    assign scan_tc = (presc == SCAN_TC);

    always_comb begin
        idx_nxt = idx;
        if (scan_tc) begin
            idx_nxt = (idx == LAST_DIGIT) ? '0 : idx + 1'b1;
        end
    end

    // an and seg are both registered from idx_nxt so they change on the very
    // edge the index advances; selecting seg from the old index would show
    // the previous digit's pattern for one cycle under the new anode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
            an    <= 4'b1110;
            seg   <= 7'b1000000;
        end else begin
            presc <= scan_tc ? '0 : presc + 1'b1;
            idx   <= idx_nxt;
            an    <= anode_decode(idx_nxt);
            seg   <= hex_to_seg(nibble_at(bin_out, idx_nxt));
        end
    end

    // -------------------------------------------------------------------------
    // Transition checker
    // -------------------------------------------------------------------------
`ifdef GRAY_CHECK_EN
    logic [N-1:0] g_diff;
    logic         multi_bit;

    // x & (x-1) clears the lowest set bit; anything left means two or more
    // bits flipped. Zero or one flipped bit is a legal Gray step.
    assign g_diff    = g_q ^ g_prev;
    assign multi_bit = ((g_diff & (g_diff - 1'b1)) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (multi_bit) begin
            err <= 1'b1;
        end
    end

    // Decoded from registered state so it tracks the lit digit exactly.
    assign dp = ~(err && (idx == '0));
`else
    assign err = 1'b0;
    assign dp  = 1'b1;
`endif

endmodule

// File: tb/tb_gray_display_driver.sv
// -----------------------------------------------------------------------------
// tb_gray_display_driver
//
// Drives gray_display_driver (N=8, SCAN_MAX=3) with directed vectors. A
// behavioural model (sample history, arithmetic Gray decode, division-based
// scan position) is compared against every output on every falling edge,
// and directed literal expectations pin the model at key points.
// Expectations for err/dp follow GRAY_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_gray_display_driver;

    localparam int N        = 8;
    localparam int SCAN_MAX = 3;
    localparam int DIGITS   = N / 4;
    localparam int DWELL    = SCAN_MAX + 1;

`ifdef GRAY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic [N-1:0] gray_in = '0;
    logic [N-1:0] bin_out;
    logic         step;
    logic         err;
    logic [3:0]   an;
    logic [6:0]   seg;
    logic         dp;

    int checks   = 0;
    int failures = 0;
    int steps    = 0;

    always #5 clk = ~clk;

    gray_display_driver #(
        .N        (N),
        .SCAN_MAX (SCAN_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .gray_in (gray_in),
        .bin_out (bin_out),
        .step    (step),
        .err     (err),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Binary value of a Gray word: XOR of the word with all its right shifts.
    function automatic logic [N-1:0] to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = g;
        for (int s = 1; s < N; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    // -------------------------------------------------------------------------
    // Model: last three sampled gray_in values, sticky error, edge count.
    // Registers reset to zero, so pre-reset history is zero.
    // -------------------------------------------------------------------------
    logic [N-1:0] h0 = '0;   // sampled at the latest edge
    logic [N-1:0] h1 = '0;   // one edge earlier
    logic [N-1:0] h2 = '0;   // two edges earlier
    logic         m_err = 1'b0;
    int           cyc = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h0    <= '0;
            h1    <= '0;
            h2    <= '0;
            m_err <= 1'b0;
            cyc   <= 0;
        end else begin
            h0  <= gray_in;
            h1  <= h0;
            h2  <= h1;
            cyc <= cyc + 1;
            if ($countones(h0 ^ h1) >= 2) m_err <= 1'b1;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int           digit;
        logic [N-1:0] shown;
        logic [3:0]   nib;
        digit = (cyc / DWELL) % DIGITS;
        shown = to_bin(h2);
        nib   = 4'((shown >> (4 * digit)) & 8'hF);
        check("m_bin",  {24'd0, bin_out}, {24'd0, to_bin(h1)});
        check("m_step", {31'd0, step},    {31'd0, (h1 != h2)});
        check("m_err",  {31'd0, err},     {31'd0, (CHK & m_err)});
        check("m_an",   {28'd0, an},      {28'd0, (4'hF & ~(4'h1 << digit))});
        check("m_seg",  {25'd0, seg},     {25'd0, SEG_TBL[nib]});
        check("m_dp",   {31'd0, dp},      {31'd0, !(CHK && m_err && digit == 0)});
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic drive(input logic [N-1:0] v);
        @(posedge clk);
        #2;
        gray_in = v;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (step === 1'b1) steps++;
        end
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 4 * DWELL && !hit; k++) begin
            @(negedge clk);
            if (an === target) hit = 1'b1;
        end
        if (!hit) check({name, "_timeout"}, {28'd0, an}, {28'd0, target});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_an",   {28'd0, an},      32'h0000_000E);
        check("rst_seg",  {25'd0, seg},     32'h0000_0040);
        check("rst_bin",  {24'd0, bin_out}, 32'h0);
        check("rst_err",  {31'd0, err},     32'h0);
        check("rst_dp",   {31'd0, dp},      32'h1);
        check("rst_step", {31'd0, step},    32'h0);

        // Scan: digit 1 after one dwell, back to digit 0 after another.
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scan_an1", {28'd0, an}, 32'h0000_000D);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scan_an0", {28'd0, an}, 32'h0000_000E);

        // Full Gray count 1..255, then wrap 0x80 -> 0x00.
        steps = 0;
        for (int i = 1; i < 256; i++) begin
            drive(N'(i ^ (i >> 1)));
            tick(10);
        end
        check("seq_bin_255",  {24'd0, bin_out}, 32'd255);
        drive('0);
        tick(10);
        check("seq_wrap_bin", {24'd0, bin_out}, 32'd0);
        check("seq_err",      {31'd0, err},     32'd0);
        check("seq_steps",    steps,            32'd256);

        // Checker: 0x01 -> 0x02 flips two bits.
        drive(8'h01);
        tick(10);
        check("chk_pre_err", {31'd0, err}, 32'd0);
        drive(8'h02);
        tick(2);
        check("chk_err_early", {31'd0, err},     32'd0);
        tick(1);
        check("chk_err",       {31'd0, err},     {31'd0, CHK});
        check("chk_bin",       {24'd0, bin_out}, 32'h03);

        wait_an(4'b1110, "dp_wait0");
        check("dp_digit0", {31'd0, dp}, {31'd0, !CHK});
        wait_an(4'b1101, "dp_wait1");
        check("dp_digit1", {31'd0, dp}, 32'd1);

        // Further legal steps keep err held.
        drive(8'h06);
        tick(10);
        drive(8'h07);
        tick(10);
        check("chk_hold_err", {31'd0, err},     {31'd0, CHK});
        check("chk_hold_bin", {24'd0, bin_out}, 32'h05);

        // Asynchronous reset mid-dwell on digit 1, between clock edges.
        wait_an(4'b1101, "arst_wait");
        @(posedge clk);
        #2;
        rst     = 1'b0;
        gray_in = '0;
        #1;
        check("arst_err",  {31'd0, err},     32'd0);
        check("arst_dp",   {31'd0, dp},      32'd1);
        check("arst_an",   {28'd0, an},      32'h0000_000E);
        check("arst_seg",  {25'd0, seg},     32'h0000_0040);
        check("arst_bin",  {24'd0, bin_out}, 32'd0);
        check("arst_step", {31'd0, step},    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Decode and scan: Gray 0x38 is binary 0x2F.
        drive(8'h38);
        tick(4);
        check("dec_bin", {24'd0, bin_out}, 32'h2F);
        wait_an(4'b1110, "dec_wait0");
        check("dec_seg0", {25'd0, seg}, {25'd0, 7'b0001110});
        wait_an(4'b1101, "dec_wait1");
        check("dec_seg1", {25'd0, seg}, {25'd0, 7'b0100100});
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_display_driver.md
# gray_display_driver

Downstream consumer of the N-bit Gray counter output. It re-registers the Gray word, converts it to binary, and flags any illegal multi-bit Gray transition. It scans the binary value as hexadecimal onto a multiplexed, common-anode seven-segment display, replacing direct LED viewing of the raw code.

## Interface
- N, 8, Gray/binary width; multiple of 4, range 4..16; DIGITS = N/4.
- SCAN_MAX, 100000-1, prescaler terminal count; each digit is lit for SCAN_MAX+1 clk cycles (1 ms at 100 MHz).
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- gray_in  input  N  Gray code from the counter; changes on clk edges.
- bin_out  output  N  registered binary equivalent of gray_in.
- step  output  1  one-cycle pulse when the registered Gray value changes.
- err  output  1  sticky flag: a transition changed more than one bit.
- an  output  4  active-low digit enables; an[0] is the least-significant nibble.
- seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.

## Operation
- Capture: g_q <= gray_in every cycle. g_prev <= g_q every cycle. Both registers reset to 0.
- Conversion: b[N-1] = g_q[N-1]; b[i] = b[i+1] ^ g_q[i]. The result is registered into bin_out.
- step: registered as (g_q != g_prev), so it rises in the same cycle that bin_out shows the new value.
- Checker: if popcount(g_q ^ g_prev) >= 2, err is set and held until reset. A single-bit change or no change leaves err unchanged.
- Prescaler: counts 0..SCAN_MAX. At the terminal count it wraps to 0 and the digit index advances 0, 1, ..., DIGITS-1, 0.
- Digit select: an = active-low one-hot of the digit index. Anodes at DIGITS and above are always 1.
- Segment decode: seg is registered every cycle from the nibble of bin_out selected by the current digit index, using this table:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp: 0 only when err=1 and digit index = 0; otherwise 1.
- Reset values: g_q=0, g_prev=0, bin_out=0, step=0, err=0, prescaler=0, digit index=0, an=1110, seg=1000000, dp=1.

## Timing
- gray_in to bin_out/step: 2 clk cycles.
- gray_in to err: 2 cycles.
- bin_out change to seg on the displayed digit: 1 cycle.
- Digit change: the index advances on the cycle after the prescaler reaches SCAN_MAX. an and seg both update in that cycle, with no cycle where they disagree (no ghosting).
- Back-to-back changes of gray_in on consecutive cycles are each checked and each produce a step pulse.
- Wrap-around (e.g. 10000000 -> 00000000 for N=8) is a legal single-bit change. bin_out goes 255 -> 0.
- Reset assertion mid-scan forces all reset values immediately, independent of clk. After deassertion, scanning restarts at digit 0 with a full dwell.
- err is not cleared by any input except rst.

## Configuration
- GRAY_CHECK_EN defined: the checker, err and dp behaviour are as specified above.
- GRAY_CHECK_EN undefined: the checker logic is removed; err is tied to 0 and dp to 1. All other behaviour is unchanged.

## Test plan
Use SCAN_MAX=3 and N=8 unless stated.
- Reset check: hold rst=0, then release -> an=1110, seg=1000000, bin_out=0, err=0, dp=1. an becomes 1101 after 4 cycles and returns to 1110 after 4 more.
- Full sequence: drive a Gray count of 0..255 with one change every 10 cycles -> bin_out tracks the count with 2-cycle latency, one step pulse per change, err stays 0 across the 128 -> 0 wrap.
- Decode and scan: gray_in=0x38 (binary 0x2F) -> digit 0 shows seg=0001110 (F), digit 1 shows seg=0100100 (2), an never has two zero bits.
- Checker: gray_in 0x01 -> 0x02 (2 bits change) -> err=1 two cycles later. dp=0 only while an=1110. err is held through further legal steps until rst.
- Async reset: assert rst mid-dwell while err=1, with no clk edge -> all outputs take reset values immediately.
- Checker compiled out: GRAY_CHECK_EN undefined, repeat the checker stimulus -> err=0, dp=1, bin_out still 0x03.
